// File: rtl/commit_trace_buffer_if.sv
// Read-side port of the commit trace buffer.
// Carries the valid/ready handshake and the head record fields.
//   out_valid  head record available (driven by the buffer)
//   out_ready  reader accepts the head record (driven by the reader)
//   rec_kind   0 = register write, 1 = memory store
//   rec_pc     PC of the capture cycle
//   rec_addr   register number (zero-extended) or memory address
//   rec_data   written value
interface commit_trace_buffer_if #(
  parameter int PC_W   = 32,
  parameter int ADDR_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic              rec_kind;
  logic [PC_W-1:0]   rec_pc;
  logic [ADDR_W-1:0] rec_addr;
  logic [31:0]       rec_data;

  modport master (output out_valid, rec_kind, rec_pc, rec_addr, rec_data,
                  input  out_ready);
  modport slave  (input  out_valid, rec_kind, rec_pc, rec_addr, rec_data,
                  output out_ready);
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures architectural side effects (data-memory
// stores and non-R0 register writebacks) tagged with their PC into a
// first-word-fall-through FIFO drained by a debug reader.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   en                  capture enable
//   pc                  PC tagged onto this cycle's events
//   wb_we/addr/data     register writeback
//   dm_we/re/addr/data  data-memory access (store = we & ~re)
//   rd                  read port (valid/ready plus record fields)
//   count               current occupancy, 0..DEPTH
//   drop_cnt            saturating count of events lost to lack of space
//   overflow            sticky drop flag
//   clr_stats           clears drop_cnt and overflow
module commit_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 32,
  parameter int ADDR_W = 32,
  parameter int DROP_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PC_W-1:0]         pc,
  input  logic                    wb_we,
  input  logic [4:0]              wb_addr,
  input  logic [31:0]             wb_data,
  input  logic                    dm_we,
  input  logic                    dm_re,
  input  logic [ADDR_W-1:0]       dm_addr,
  input  logic [31:0]             dm_data,
  commit_trace_buffer_if.master   rd,
  output logic [$clog2(DEPTH):0]  count,
  output logic [DROP_W-1:0]       drop_cnt,
  output logic                    overflow,
  input  logic                    clr_stats
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic              mem_kind [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [31:0]       mem_data [DEPTH];

  logic [AW-1:0]     wptr, rptr, wptr2;
  logic              st_ev, rg_ev, pop, push_st, push_rg, head_valid;
  logic [CW:0]       space;
  logic [1:0]        n_push, n_drop;
  logic [DROP_W:0]   drop_sum;

  // Space includes the slot freed by a same-cycle pop; the store takes
  // precedence, so the reg event needs one more slot when the store fits.
  always_comb begin
    head_valid = (count != '0);
    st_ev      = en & dm_we & ~dm_re;
    rg_ev      = en & wb_we & (wb_addr != 5'd0);
    pop        = head_valid & rd.out_ready;
    space      = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
    push_st    = st_ev & (space >= (CW+1)'(1));
    push_rg    = rg_ev & (push_st ? (space >= (CW+1)'(2)) : (space >= (CW+1)'(1)));
    n_push     = {1'b0, push_st} + {1'b0, push_rg};
    n_drop     = {1'b0, st_ev & ~push_st} + {1'b0, rg_ev & ~push_rg};
    wptr2      = wptr + AW'(push_st);
    drop_sum   = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);
  end

  // Head record falls through combinationally; fields are zero when empty.
  always_comb begin
    rd.out_valid = head_valid;
    rd.rec_kind  = head_valid ? mem_kind[rptr] : 1'b0;
    rd.rec_pc    = head_valid ? mem_pc[rptr]   : '0;
    rd.rec_addr  = head_valid ? mem_addr[rptr] : '0;
    rd.rec_data  = head_valid ? mem_data[rptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      wptr  <= wptr + AW'(n_push);
      rptr  <= rptr + AW'(pop);
      count <= count + CW'(n_push) - CW'(pop);
      // A drop in the clearing cycle wins: the count restarts at this
      // cycle's drops instead of zero.
      if (clr_stats)
        drop_cnt <= DROP_W'(n_drop);
      else if (drop_sum[DROP_W])
        drop_cnt <= '1;
      else
        drop_cnt <= drop_sum[DROP_W-1:0];
      if (n_drop != 2'd0)
        overflow <= 1'b1;
      else if (clr_stats)
        overflow <= 1'b0;
    end
  end

  // Storage needs no reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_st) begin
        mem_kind[wptr] <= 1'b1;
        mem_pc[wptr]   <= pc;
        mem_addr[wptr] <= dm_addr;
        mem_data[wptr] <= dm_data;
      end
      if (push_rg) begin
        mem_kind[wptr2] <= 1'b0;
        mem_pc[wptr2]   <= pc;
        mem_addr[wptr2] <= ADDR_W'(wb_addr);
        mem_data[wptr2] <= wb_data;
      end
    end
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Hardware commit-trace FIFO downstream of the pipelined core's memory and writeback stages.
- Captures each architectural side effect as a tagged record: data-memory stores and non-R0 register writebacks, each with the issuing PC.
- Records drain through a valid/ready port to a debug reader, replacing simulation-only display monitoring.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 4
PC_W, 32, PC field width
ADDR_W, 32, address field width; register numbers are zero-extended into it
DROP_W, 16, dropped-event counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
en  in  1  capture enable; 0 = no new events accepted, not counted as drops
pc  in  PC_W  PC tagged onto this cycle's events
wb_we  in  1  register writeback enable
wb_addr  in  5  writeback register number
wb_data  in  32  writeback value
dm_we  in  1  data-memory write enable
dm_re  in  1  data-memory read enable
dm_addr  in  ADDR_W  data-memory address
dm_data  in  32  store data
out_valid  out  1  head record available
out_ready  in  1  reader accepts head record
rec_kind  out  1  0 = register write, 1 = memory store
rec_pc  out  PC_W  record PC
rec_addr  out  ADDR_W  register number (zero-extended) or memory address
rec_data  out  32  written value
count  out  $clog2(DEPTH)+1  current occupancy
drop_cnt  out  DROP_W  events lost to lack of space; saturating
overflow  out  1  sticky; set on any drop
clr_stats  in  1  clears drop_cnt and overflow

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied; out_valid=0, count=0, drop_cnt=0, overflow=0; rec_* = 0. Reset mid-operation discards all entries and ignores that cycle's events.
- Event qualification, sampled at posedge:
  - store event = en & dm_we & ~dm_re
  - reg event = en & wb_we & (wb_addr != 0)
  - Both may occur in one cycle.
- Push order within a cycle: store first, then reg event. A cycle may push 0, 1 or 2 entries.
- Free space = DEPTH - count + (pop this cycle ? 1 : 0), where pop = out_valid & out_ready. A pop at full frees a slot for the same-cycle push.
- Insufficient space:
  - Push events in order until space is exhausted; drop the remainder.
  - Each dropped event increments drop_cnt by 1, saturating at all-ones.
  - Any drop sets overflow.
  - Example: space 1 with both events -> store kept, reg event dropped, drop_cnt +1.
- clr_stats=1 zeroes drop_cnt and overflow. A drop in the same cycle takes priority: drop_cnt = number dropped that cycle, overflow = 1.
- Output is first-word-fall-through:
  - rec_* reflect the head entry whenever out_valid=1.
  - A record pushed into an empty FIFO appears with out_valid=1 on the cycle after its capture edge (latency 1).
  - rec_* forced to 0 while out_valid=0.
- Handshake:
  - While out_valid=1 and out_ready=0, rec_* hold stable.
  - out_ready while empty has no effect.
- Record fields:
  - Store records: rec_addr = dm_addr, rec_data = dm_data.
  - Reg records: rec_addr = {zeros, wb_addr}, rec_data = wb_data.
  - Both carry rec_pc = pc of the capture cycle.
- Pointers wrap modulo DEPTH. count updates by pushes minus pop each cycle, range 0..DEPTH.

Test Plan:
- Reg write R3=42 at pc=8, out_ready=1 -> next cycle out_valid=1, rec_kind=0, rec_pc=8, rec_addr=3, rec_data=42; popped; count returns to 0.
- wb_we=1 with wb_addr=0, plus dm_we=1 with dm_re=1 -> nothing pushed, count=0, drop_cnt=0.
- Simultaneous store MEM[0x10]=7 and R5=9 at pc=12 -> count=2; head is kind=1, addr=0x10, data=7; then kind=0, addr=5, data=9.
- out_ready=0, DEPTH-1 entries present, then store+reg together -> count=DEPTH, store kept, drop_cnt=1, overflow=1. Further single event -> drop_cnt=2. clr_stats -> both 0.
- Full FIFO, out_ready=1, one reg event same cycle -> count stays DEPTH, drop_cnt unchanged, new record emerges last in order.
- 5 entries queued, out_ready=0 for 3 cycles -> rec_* stable. Assert rst for one cycle -> out_valid=0, count=0, rec_*=0, stats 0.
